// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encoding and helpers shared by uart_rx and uart_tx.
package uart_pkg;

    localparam int SYS_FRE = 24000000;
    localparam int BPS     = 115200;
    localparam int DIV_CLK = (SYS_FRE / BPS) >> 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Bit-index encoding reported on no_bit_rx (and the matching uart_tx debug port)
    localparam logic [3:0] START_BIT  = 4'd1;
    localparam logic [3:0] DATA_FIRST = 4'd2;
    localparam logic [3:0] DATA_LAST  = 4'd9;
    localparam logic [3:0] PARITY_BIT = 4'd10;
    localparam logic [3:0] STOP_BIT   = 4'd11;

    // 2-of-3 vote used by the optional majority sampler
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divide-by-DIV counter producing a one-clock tick
// at terminal count. The synchronous clear lets the receiver re-phase the
// counter onto a detected start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = DIV_CLK
) (
    input  logic clk24m,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt_tick;

    assign tick = (cnt_tick == TC);

    // Count 0..DIV-1, wrapping at terminal count or on clear
    always_ff @(posedge clk24m) begin
        if (rst || clr || tick) begin
            cnt_tick <= '0;
        end else begin
            cnt_tick <= cnt_tick + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, 8 data bits LSB first, even parity,
// one stop bit. Host reads through a holding register with rdrf/pe/fe/oe flags
// cleared by a falling edge on rdn.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 vote over oversample
// phases 6/7/8 (decision at phase 8) instead of a single sample at phase 7.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on the synchronized input
// START  | validating the start bit at mid-bit; a high sample is a false start
// DATA   | shifting in 8 data bits, LSB first, accumulating parity
// PARITY | folding the parity bit into the running parity
// STOP   | sampling the stop bit; the frame completes at mid-stop
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk24m,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rdn,
    output logic [7:0] dat_out,
    output logic       rdrf,
    output logic       pe,
    output logic       fe,
    output logic       oe,
    output logic       busy,
    output logic [3:0] no_bit_rx
);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_PHASE = 4'd8;
`else
    localparam logic [3:0] SAMPLE_PHASE = 4'd7;
`endif

    logic        rx_s1;
    logic        rxs;
    logic        rxs_d;
    logic        rdn_r;
    logic        rdn_d;
    logic        rx_fall;
    logic        rd_edge;
    logic        start_det;

    logic        tick;
    logic [3:0]  cnt16;
    logic        samp_pt;
    logic        bit_end;
    logic        samp;

    uart_state_t state;
    uart_state_t state_nxt;

    logic        shift_en;
    logic        par_en;
    logic        bit_adv;
    logic        complete;

    logic [7:0]  rsr;
    logic        par;

    // Two-flop synchronizer on rxd plus registered rdn, both idling high
    always_ff @(posedge clk24m) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            rdn_r <= 1'b1;
            rdn_d <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rxs   <= rx_s1;
            rxs_d <= rxs;
            rdn_r <= rdn;
            rdn_d <= rdn_r;
        end
    end

    assign rx_fall   = rxs_d & ~rxs;
    assign rd_edge   = rdn_d & ~rdn_r;
    assign start_det = (state == IDLE) && rx_fall;

    uart_baud_tick #(
        .DIV (DIV_CLK)
    ) u_baud_tick (
        .clk24m (clk24m),
        .rst    (rst),
        .clr    (start_det),
        .tick   (tick)
    );

    // Oversample phase within the current bit, re-aligned on each start edge
    always_ff @(posedge clk24m) begin
        if (rst || start_det) begin
            cnt16 <= 4'd0;
        end else if (tick) begin
            cnt16 <= cnt16 + 4'd1;
        end
    end

    assign samp_pt = tick && (cnt16 == SAMPLE_PHASE);
    assign bit_end = tick && (cnt16 == 4'd15);

`ifdef UART_RX_MAJORITY_EN
    logic vote6;
    logic vote7;

    // Capture the early votes; the third vote is the live input at phase 8
    always_ff @(posedge clk24m) begin
        if (rst) begin
            vote6 <= 1'b1;
            vote7 <= 1'b1;
        end else if (tick) begin
            if (cnt16 == 4'd6) vote6 <= rxs;
            if (cnt16 == 4'd7) vote7 <= rxs;
        end
    end

    assign samp = maj3(vote6, vote7, rxs);
`else
    assign samp = rxs;
`endif

    // State register
    always_ff @(posedge clk24m) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_fall) state_nxt = START;
            end
            START: begin
                if (samp_pt && samp) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (no_bit_rx == DATA_LAST)) state_nxt = PARITY;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (samp_pt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        shift_en = 1'b0;
        par_en   = 1'b0;
        bit_adv  = 1'b0;
        complete = 1'b0;
        case (state)
            START: begin
                bit_adv = bit_end;
            end
            DATA: begin
                shift_en = samp_pt;
                bit_adv  = bit_end;
            end
            PARITY: begin
                par_en  = samp_pt;
                bit_adv = bit_end;
            end
            STOP: begin
                complete = samp_pt;
            end
            default: begin
                shift_en = 1'b0;
            end
        endcase
    end

    // Bit index, shift register, running parity and busy flag
    always_ff @(posedge clk24m) begin
        if (rst) begin
            no_bit_rx <= 4'd0;
            rsr       <= 8'd0;
            par       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (start_det) begin
                no_bit_rx <= START_BIT;
                par       <= 1'b0;
            end else begin
                if (state_nxt == IDLE) begin
                    no_bit_rx <= 4'd0;
                end else if (bit_adv) begin
                    no_bit_rx <= no_bit_rx + 4'd1;
                end
                if (shift_en) begin
                    rsr <= {samp, rsr[7:1]};
                    par <= par ^ samp;
                end else if (par_en) begin
                    par <= par ^ samp;
                end
            end
        end
    end

    // Host holding register; a completing frame takes priority over a read edge
    always_ff @(posedge clk24m) begin
        if (rst) begin
            dat_out <= 8'd0;
            rdrf    <= 1'b0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            oe      <= 1'b0;
        end else if (complete) begin
            dat_out <= rsr;
            rdrf    <= 1'b1;
            pe      <= par;
            fe      <= ~samp;
            oe      <= rdrf & ~rd_edge;
        end else if (rd_edge) begin
            rdrf <= 1'b0;
            pe   <= 1'b0;
            fe   <= 1'b0;
            oe   <= 1'b0;
        end
    end

endmodule
